// File: rtl/memory_responder.sv
// memory_responder: arbitrates instruction fetches and data accesses onto a
// single RAM port. Data requests win over fetches, every access passes back
// through IDLE before the next one starts, and an access that waits too long
// for ramready is abandoned and recorded in a sticky error flag.
module memory_responder #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        memerr
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [CW-1:0] r_waitCnt;
  logic [CW-1:0] w_nextCnt;
  logic          r_memErr;
  logic          w_setErr;

  // Next-state, wait-counter and output decode; the counter only advances
  // while an access stays put, so any transition clears it. Outputs are
  // forced to zero while reset is held so an in-flight access never hits.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = '0;
    w_setErr    = 1'b0;
    ihit        = 1'b0;
    iload       = 32'd0;
    dhit        = 1'b0;
    dload       = 32'd0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = 32'd0;
    ramstore    = 32'd0;

    case (r_state)
      IDLE: begin
        if (dREN || dWEN) begin
          w_nextState = DACC;
        end else if (iREN) begin
          w_nextState = IACC;
        end
      end

      DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN && !dWEN;
        if (!(dREN || dWEN)) begin
          w_nextState = IDLE;
        end else if (ramready) begin
          dhit        = 1'b1;
          dload       = ramload;
          w_nextState = IDLE;
        end else if (r_waitCnt == LAST_CNT) begin
          w_setErr    = 1'b1;
          w_nextState = IDLE;
        end else begin
          w_nextCnt = r_waitCnt + 1'b1;
        end
      end

      IACC: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        if (!iREN) begin
          w_nextState = IDLE;
        end else if (ramready) begin
          ihit        = 1'b1;
          iload       = ramload;
          w_nextState = IDLE;
        end else if (r_waitCnt == LAST_CNT) begin
          w_setErr    = 1'b1;
          w_nextState = IDLE;
        end else begin
          w_nextCnt = r_waitCnt + 1'b1;
        end
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase

    if (RST) begin
      ihit     = 1'b0;
      iload    = 32'd0;
      dhit     = 1'b0;
      dload    = 32'd0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = 32'd0;
      ramstore = 32'd0;
    end
  end

  // State, wait counter and sticky error flag; the error is only cleared by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_waitCnt <= '0;
      r_memErr  <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextCnt;
      if (w_setErr) begin
        r_memErr <= 1'b1;
      end
    end
  end

  assign memerr = r_memErr;

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed cycle-by-cycle vectors against memory_responder
// with TIMEOUT=4; every expected value below is worked out by hand.
module tb_memory_responder;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic [31:0] iload;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        memerr;

  int vecCount;
  int missCount;

  memory_responder #(.TIMEOUT(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .ihit     (ihit),
    .iload    (iload),
    .dhit     (dhit),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramready (ramready)
    ,.memerr  (memerr)
  );

  // 10 ns clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive every input for the current cycle, then let the combinational outputs settle.
  task automatic applyStimulus(input logic rst, input logic iren, input logic [31:0] ia,
                               input logic dren, input logic dwen, input logic [31:0] da,
                               input logic [31:0] ds, input logic rdy, input logic [31:0] rl);
    RST      = rst;
    iREN     = iren;
    iaddr    = ia;
    dREN     = dren;
    dWEN     = dwen;
    daddr    = da;
    dstore   = ds;
    ramready = rdy;
    ramload  = rl;
    #2;
  endtask

  // Advance to just after the next rising edge.
  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vecCount  = 0;
    missCount = 0;

    // Reset with garbage-free inputs, then check outputs while RST is still high.
    applyStimulus(1, 1, 32'h40, 0, 0, 32'h0, 32'h0, 1, 32'h1111_1111);
    nextCycle();
    nextCycle();
    applyStimulus(1, 1, 32'h40, 0, 0, 32'h0, 32'h0, 1, 32'h1111_1111);
    checkOutput("rst_ihit",    ihit,    0);
    checkOutput("rst_ramREN",  ramREN,  0);
    checkOutput("rst_ramaddr", ramaddr, 0);
    checkOutput("rst_iload",   iload,   0);
    checkOutput("rst_memerr",  memerr,  0);

    // Load: ready on the 3rd DACC cycle.
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h100, 32'h0, 0, 32'h0);
    checkOutput("ld_idle_ramREN", ramREN, 0);
    checkOutput("ld_idle_dhit",   dhit,   0);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h100, 32'h0, 0, 32'h0);
    checkOutput("ld_c1_ramREN",  ramREN,  1);
    checkOutput("ld_c1_ramaddr", ramaddr, 32'h100);
    checkOutput("ld_c1_dhit",    dhit,    0);
    checkOutput("ld_c1_dload",   dload,   0);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h100, 32'h0, 0, 32'h0);
    checkOutput("ld_c2_ramREN",  ramREN,  1);
    checkOutput("ld_c2_ramaddr", ramaddr, 32'h100);
    checkOutput("ld_c2_dhit",    dhit,    0);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h100, 32'h0, 1, 32'hDEAD_BEEF);
    checkOutput("ld_c3_ramREN", ramREN, 1);
    checkOutput("ld_c3_dhit",   dhit,   1);
    checkOutput("ld_c3_dload",  dload,  32'hDEAD_BEEF);
    checkOutput("ld_c3_ramWEN", ramWEN, 0);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
    checkOutput("ld_done_ramREN",  ramREN,  0);
    checkOutput("ld_done_ramaddr", ramaddr, 0);
    checkOutput("ld_done_dhit",    dhit,    0);
    checkOutput("ld_done_dload",   dload,   0);
    nextCycle();

    // Simultaneous store and fetch: store first, then an IDLE cycle, then the fetch.
    applyStimulus(0, 1, 32'h40, 0, 1, 32'h200, 32'h1234_5678, 1, 32'hAAAA_5555);
    checkOutput("sim_idle_dhit", dhit, 0);
    checkOutput("sim_idle_ihit", ihit, 0);
    nextCycle();
    applyStimulus(0, 1, 32'h40, 0, 1, 32'h200, 32'h1234_5678, 1, 32'hAAAA_5555);
    checkOutput("sim_st_ramWEN",   ramWEN,   1);
    checkOutput("sim_st_ramREN",   ramREN,   0);
    checkOutput("sim_st_ramaddr",  ramaddr,  32'h200);
    checkOutput("sim_st_ramstore", ramstore, 32'h1234_5678);
    checkOutput("sim_st_dhit",     dhit,     1);
    checkOutput("sim_st_ihit",     ihit,     0);
    nextCycle();
    applyStimulus(0, 1, 32'h40, 0, 0, 32'h200, 32'h1234_5678, 1, 32'hAAAA_5555);
    checkOutput("sim_gap_ihit",   ihit,   0);
    checkOutput("sim_gap_dhit",   dhit,   0);
    checkOutput("sim_gap_ramREN", ramREN, 0);
    nextCycle();
    applyStimulus(0, 1, 32'h40, 0, 0, 32'h200, 32'h1234_5678, 1, 32'hAAAA_5555);
    checkOutput("sim_if_ihit",     ihit,     1);
    checkOutput("sim_if_iload",    iload,    32'hAAAA_5555);
    checkOutput("sim_if_ramaddr",  ramaddr,  32'h40);
    checkOutput("sim_if_ramstore", ramstore, 0);
    checkOutput("sim_if_dhit",     dhit,     0);
    nextCycle();
    applyStimulus(0, 0, 32'h40, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    nextCycle();

    // Boundary: ready on the TIMEOUT-th IACC cycle completes without error.
    applyStimulus(0, 1, 32'h80, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    nextCycle();
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 1, 32'h80, 0, 0, 32'h0, 32'h0, 0, 32'h0);
      checkOutput("bnd_wait_ihit", ihit, 0);
      nextCycle();
    end
    applyStimulus(0, 1, 32'h80, 0, 0, 32'h0, 32'h0, 1, 32'h0BAD_F00D);
    checkOutput("bnd_ihit",  ihit,  1);
    checkOutput("bnd_iload", iload, 32'h0BAD_F00D);
    nextCycle();
    applyStimulus(0, 0, 32'h80, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("bnd_memerr", memerr, 0);
    nextCycle();

    // Abort: dREN dropped on the 2nd DACC cycle.
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h300, 32'h0, 0, 32'h0);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h300, 32'h0, 0, 32'h0);
    checkOutput("ab_c1_ramREN", ramREN, 1);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h300, 32'h0, 1, 32'h5555_AAAA);
    checkOutput("ab_c2_dhit",   dhit,   0);
    checkOutput("ab_c2_dload",  dload,  0);
    checkOutput("ab_c2_ramREN", ramREN, 0);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h300, 32'h0, 1, 32'h5555_AAAA);
    checkOutput("ab_idle_ramaddr", ramaddr, 0);
    checkOutput("ab_idle_ramREN",  ramREN,  0);
    checkOutput("ab_idle_ramWEN",  ramWEN,  0);
    checkOutput("ab_idle_dhit",    dhit,    0);
    nextCycle();

    // Timeout: four IACC cycles without ready, then memerr stays set.
    applyStimulus(0, 1, 32'h44, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    nextCycle();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 1, 32'h44, 0, 0, 32'h0, 32'h0, 0, 32'h0);
      checkOutput("to_wait_ihit",   ihit,   0);
      checkOutput("to_wait_memerr", memerr, 0);
      checkOutput("to_wait_ramREN", ramREN, 1);
      nextCycle();
    end
    applyStimulus(0, 1, 32'h44, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("to_memerr", memerr, 1);
    checkOutput("to_ramREN", ramREN, 0);
    checkOutput("to_ihit",   ihit,   0);
    nextCycle();
    applyStimulus(0, 1, 32'h44, 0, 0, 32'h0, 32'h0, 1, 32'h1357_9BDF);
    checkOutput("to_after_ihit",   ihit,   1);
    checkOutput("to_after_iload",  iload,  32'h1357_9BDF);
    checkOutput("to_after_memerr", memerr, 1);
    nextCycle();
    applyStimulus(0, 0, 32'h44, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("to_sticky_memerr", memerr, 1);
    nextCycle();

    // Reset in the middle of a fetch.
    applyStimulus(0, 1, 32'h48, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    nextCycle();
    applyStimulus(0, 1, 32'h48, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("mr_c1_ramREN", ramREN, 1);
    nextCycle();
    applyStimulus(1, 1, 32'h48, 0, 0, 32'h0, 32'h0, 1, 32'h2468_ACE0);
    checkOutput("mr_rst_ihit",   ihit,   0);
    checkOutput("mr_rst_iload",  iload,  0);
    checkOutput("mr_rst_ramREN", ramREN, 0);
    nextCycle();
    applyStimulus(0, 1, 32'h48, 0, 0, 32'h0, 32'h0, 1, 32'h2468_ACE0);
    checkOutput("mr_post_ramREN", ramREN, 0);
    checkOutput("mr_post_ihit",   ihit,   0);
    checkOutput("mr_post_memerr", memerr, 0);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: the maximum number of cycles one access may wait for ramready.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port iREN, input, 1 bit: instruction fetch request, held until ihit.
REQ-005 SHALL have port iaddr, input, 32 bits: fetch address.
REQ-006 SHALL have port dREN, input, 1 bit: data load request, held until dhit.
REQ-007 SHALL have port dWEN, input, 1 bit: data store request, held until dhit.
REQ-008 SHALL have port daddr, input, 32 bits: data address.
REQ-009 SHALL have port dstore, input, 32 bits: store data.
REQ-010 SHALL have port ihit, output, 1 bit: one-cycle fetch completion pulse.
REQ-011 SHALL have port iload, output, 32 bits: fetched word, valid while ihit=1.
REQ-012 SHALL have port dhit, output, 1 bit: one-cycle data completion pulse.
REQ-013 SHALL have port dload, output, 32 bits: loaded word, valid while dhit=1.
REQ-014 SHALL have port ramREN, output, 1 bit: RAM read strobe.
REQ-015 SHALL have port ramWEN, output, 1 bit: RAM write strobe.
REQ-016 SHALL have port ramaddr, output, 32 bits: RAM address.
REQ-017 SHALL have port ramstore, output, 32 bits: RAM write data.
REQ-018 SHALL have port ramload, input, 32 bits: RAM read data.
REQ-019 SHALL have port ramready, input, 1 bit: RAM completes the current access in this cycle.
REQ-020 SHALL have port memerr, output, 1 bit: sticky timeout flag.

Function
REQ-021 SHALL implement FSM states IDLE, DACC and IACC.
REQ-022 In IDLE, SHALL go to DACC next if dREN or dWEN is 1, else to IACC if iREN is 1, else stay in IDLE; data requests have priority over instruction requests.
REQ-023 In DACC, SHALL drive ramaddr=daddr and ramstore=dstore; ramWEN=dWEN, and ramREN=dREN and not dWEN (a store wins when both are set).
REQ-024 In IACC, SHALL drive ramaddr=iaddr, ramREN=1, ramWEN=0 and ramstore=0.
REQ-025 In IDLE, SHALL drive ramREN=0, ramWEN=0, ramaddr=0 and ramstore=0.
REQ-026 In DACC with ramready=1, SHALL assert dhit=1 and dload=ramload combinationally in that cycle, then go to IDLE.
REQ-027 In IACC with ramready=1, SHALL assert ihit=1 and iload=ramload combinationally in that cycle, then go to IDLE.
REQ-028 SHALL hold dload and iload at 0 whenever the matching hit is 0, and SHALL never assert ihit and dhit in the same cycle.
REQ-029 Latency: a request first seen in IDLE at cycle N SHALL produce its hit no earlier than cycle N+1; IDLE always lasts at least one cycle between accesses, so a held request is not served twice.
REQ-030 A request dropped mid-access (dREN=dWEN=0 in DACC, or iREN=0 in IACC) SHALL return the FSM to IDLE next cycle with no hit.
REQ-031 An instruction request pending during DACC SHALL wait, and SHALL be served through IDLE->IACC after dhit.
REQ-032 Wait counter: SHALL clear on entry to DACC or IACC and increment each access cycle without ramready; its width is clog2(TIMEOUT)+1.
REQ-033 If the wait counter reaches TIMEOUT-1 with ramready=0, SHALL set memerr=1, abort to IDLE next cycle with no hit, and clear the counter.
REQ-034 A ramready=1 in the same cycle as the counter reaching TIMEOUT-1 SHALL complete the access normally, with no error.
REQ-035 memerr SHALL remain 1 until reset; the FSM SHALL keep serving requests after a timeout.

Reset
REQ-036 With RST=1 at a rising edge, the FSM SHALL enter IDLE, the counter SHALL be 0 and memerr SHALL be 0.
REQ-037 While in reset, ihit, dhit, ramREN and ramWEN SHALL be 0, and iload, dload, ramaddr and ramstore SHALL be 0.
REQ-038 Reset asserted mid-access SHALL abort the access with no hit, and the RAM strobes SHALL be 0 from the cycle after that edge.

Verification
REQ-039 Load: dREN=1, daddr=0x100, ramready at the 3rd DACC cycle with ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x100 for 3 cycles, one dhit pulse with dload=0xDEADBEEF, then IDLE.
REQ-040 Simultaneous requests: iREN=dWEN=1 in IDLE -> the store is served first (ramWEN=1, ramstore=dstore); the fetch follows after one IDLE cycle; hits occur in the order dhit then ihit.
REQ-041 Timeout: iREN=1, ramready held 0, TIMEOUT=4 -> memerr=1 after 4 IACC cycles with no ihit; a later fetch with ramready=1 gives ihit=1 and memerr stays 1.
REQ-042 Boundary: ramready=1 on cycle TIMEOUT of an access -> hit is asserted and memerr stays 0.
REQ-043 Abort: dREN drops in the 2nd DACC cycle -> no dhit; IDLE next cycle; RAM strobes 0.
REQ-044 Reset: RST=1 during IACC -> no ihit, ramREN=0 the next cycle, and memerr cleared.
